// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, funct3 values and the ALU operation set.
package rv32i_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_JALR  = 3'b000;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;
  localparam logic [2:0] F3_CSRRC = 3'b011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // Maps an OP/OP-IMM funct3 to an ALU operation; alt selects SUB or SRA.
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational 32-bit ALU plus the compare flags used by branches and SLT/SLTU.
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     alu_op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  // Result selection for the requested operation.
  always_comb begin
    // NOTE: default assigned first so no path leaves result unassigned (no latch).
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, lt};
      ALU_SLTU: result = {31'b0, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_top.sv
// Single-cycle RV32I core with unified word memory, register file and CSR bank.
module rv32i_top
  import rv32i_pkg::*;
#(
  parameter int          MEM_DEPTH = 1024,
  parameter int          CSR_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic i_clk,
  input logic i_rst
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int CSR_AW = $clog2(CSR_DEPTH);

  logic [31:0] mem_bank [MEM_DEPTH];
  logic [31:0] reg_bank [32];
  logic [31:0] csr_bank [CSR_DEPTH];

  logic [31:0] pc, pc_plus4, instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_a, alu_b, alu_result;
  alu_op_e     alu_op;
  logic        cmp_eq, cmp_lt, cmp_ltu;
  logic [MEM_AW-1:0] fetch_idx, data_idx;
  logic [CSR_AW-1:0] csr_idx;
  logic [31:0] csr_old, csr_wdata, rd_data, next_pc;
  logic        rd_we, mem_we, csr_we, branch_taken;

  function automatic logic [MEM_AW-1:0] mem_index(input logic [29:0] word_addr);
    return MEM_AW'({2'b00, word_addr} % 32'(MEM_DEPTH));
  endfunction

  assign fetch_idx = mem_index(pc[31:2]);
  assign instr     = mem_bank[fetch_idx];
  assign pc_plus4  = pc + 32'd4;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign rs1_val = (rs1 == 5'd0) ? '0 : reg_bank[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : reg_bank[rs2];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign csr_idx  = CSR_AW'({20'b0, instr[31:20]} % 32'(CSR_DEPTH));
  assign csr_old  = csr_bank[csr_idx];
  assign data_idx = mem_index(alu_result[31:2]);

  // Operand and operation selection for the shared ALU.
  always_comb begin
    alu_a  = rs1_val;
    alu_b  = rs2_val;
    alu_op = ALU_ADD;
    case (opcode)
      OP:     alu_op = alu_op_decode(funct3, instr[30]);
      OP_IMM: begin
        alu_b  = imm_i;
        alu_op = alu_op_decode(funct3, (funct3 == F3_SR) && instr[30]);
      end
      LUI:    begin alu_a = '0; alu_b = imm_u; end
      AUIPC:  begin alu_a = pc; alu_b = imm_u; end
      JALR:   alu_b = imm_i;
      LOAD:   alu_b = imm_i;
      STORE:  alu_b = imm_s;
      default: ;
    endcase
  end

  rv32i_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_result),
    .eq     (cmp_eq),
    .lt     (cmp_lt),
    .ltu    (cmp_ltu)
  );

  // Write-back, store, CSR update and next-pc selection; unknown encodings fall through as NOPs.
  always_comb begin
    next_pc      = pc_plus4;
    rd_we        = 1'b0;
    rd_data      = alu_result;
    mem_we       = 1'b0;
    csr_we       = 1'b0;
    csr_wdata    = rs1_val;
    branch_taken = 1'b0;
    case (opcode)
      OP, OP_IMM, LUI, AUIPC: rd_we = 1'b1;
      BRANCH: begin
        case (funct3)
          F3_BEQ:  branch_taken = cmp_eq;
          F3_BNE:  branch_taken = !cmp_eq;
          F3_BLT:  branch_taken = cmp_lt;
          F3_BGE:  branch_taken = !cmp_lt;
          F3_BLTU: branch_taken = cmp_ltu;
          F3_BGEU: branch_taken = !cmp_ltu;
          default: branch_taken = 1'b0;
        endcase
        if (branch_taken) next_pc = pc + imm_b;
      end
      JAL: begin
        rd_we   = 1'b1;
        rd_data = pc_plus4;
        next_pc = pc + imm_j;
      end
      JALR: if (funct3 == F3_JALR) begin
        rd_we   = 1'b1;
        rd_data = pc_plus4;
        next_pc = alu_result & ~32'd1;
      end
      LOAD: if (funct3 == F3_WORD) begin
        rd_we   = 1'b1;
        rd_data = mem_bank[data_idx];
      end
      STORE: mem_we = (funct3 == F3_WORD);
      SYSTEM: begin
        case (funct3)
          F3_CSRRW: begin rd_we = 1'b1; csr_we = 1'b1;             csr_wdata = rs1_val; end
          F3_CSRRS: begin rd_we = 1'b1; csr_we = (rs1 != 5'd0);    csr_wdata = csr_old | rs1_val; end
          F3_CSRRC: begin rd_we = 1'b1; csr_we = (rs1 != 5'd0);    csr_wdata = csr_old & ~rs1_val; end
          default: ;
        endcase
        rd_data = csr_old;
      end
      default: ;
    endcase
  end

  // Program counter: the only reset state in the core.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking so every same-edge update sees pre-edge values.
    if (i_rst) pc <= RESET_PC;
    else       pc <= next_pc;
  end

  // Architectural storage updates; all suppressed while reset is asserted.
  always_ff @(posedge i_clk) begin
    // NOTE: arrays have no reset so backdoor preloads survive i_rst.
    if (!i_rst) begin
      if (rd_we && rd != 5'd0) reg_bank[rd] <= rd_data;
      if (mem_we)              mem_bank[data_idx] <= rs2_val;
      if (csr_we)              csr_bank[csr_idx] <= csr_wdata;
    end
  end

endmodule

// File: tb/tb_rv32i_top.sv
// Self-checking bench for rv32i_top: directed scenarios plus a random program run
// against an instruction-level reference model.
module tb_rv32i_top;
  import rv32i_pkg::*;

  localparam int MEM_DEPTH = 1024;
  localparam int CSR_DEPTH = 4096;
  localparam int RAND_STEPS = 250;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [MEM_DEPTH];
  logic [31:0] m_reg [32];
  logic [31:0] m_csr [CSR_DEPTH];
  logic [31:0] m_pc;

  rv32i_top #(.MEM_DEPTH(MEM_DEPTH), .CSR_DEPTH(CSR_DEPTH), .RESET_PC(32'h0)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP};
  endfunction
  function automatic logic [31:0] i_type(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] s_type(input logic [31:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], STORE};
  endfunction
  function automatic logic [31:0] b_type(input logic [31:0] imm, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BRANCH};
  endfunction
  function automatic logic [31:0] u_type(input logic [31:0] imm20, input logic [4:0] rd, input logic [6:0] opc);
    return {imm20[19:0], rd, opc};
  endfunction
  function automatic logic [31:0] j_type(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
  endfunction

  // ---------------- backdoor helpers (DUT and model together) ----------------
  task automatic poke_mem(input int idx, input logic [31:0] v);
    dut.mem_bank[idx] = v; m_mem[idx] = v;
  endtask
  task automatic poke_reg(input int idx, input logic [31:0] v);
    dut.reg_bank[idx] = v; m_reg[idx] = v;
  endtask
  task automatic poke_csr(input int idx, input logic [31:0] v);
    dut.csr_bank[idx] = v; m_csr[idx] = v;
  endtask

  // Raise reset and clear all storage; the caller preloads, then calls load_end.
  task automatic load_start();
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int i = 0; i < MEM_DEPTH; i++) poke_mem(i, 32'h0);
    for (int i = 0; i < 32; i++)        poke_reg(i, 32'h0);
    for (int i = 0; i < CSR_DEPTH; i++) poke_csr(i, 32'h0);
  endtask

  // Exactly one rising edge with reset high has elapsed when this returns.
  task automatic load_end();
    @(negedge i_clk);
    i_rst = 1'b0;
    m_pc = 32'h0;
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // ---------------- reference model: one architectural instruction ----------------
  task automatic model_step();
    logic [31:0] ins, a, b, ii, is_, ib, ij, iu, res, npc, addr, old;
    logic signed [31:0] s20, s25, s31, sa;
    logic [4:0] rd, rs1, rs2, sh;
    logic [2:0] f3;
    bit wr, taken;
    int csr_i;
    ins = m_mem[(m_pc >> 2) % MEM_DEPTH];
    rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20];
    a = (rs1 == 0) ? 32'h0 : m_reg[rs1];
    b = (rs2 == 0) ? 32'h0 : m_reg[rs2];
    s20 = $signed(ins) >>> 20;
    s25 = $signed(ins) >>> 25;
    s31 = $signed(ins) >>> 31;
    ii  = s20;
    is_ = (s25 << 5) | 32'(ins[11:7]);
    ib  = (s31 << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    ij  = (s31 << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    iu  = ins & 32'hFFFF_F000;
    npc = m_pc + 4;
    wr = 0; res = 0;
    case (ins[6:0])
      OP, OP_IMM: begin
        wr = 1;
        if (ins[6:0] == OP_IMM) b = ii;
        sh = b[4:0];
        case (f3)
          0: res = (ins[6:0] == OP && ins[30]) ? a - b : a + b;
          1: res = a << sh;
          2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3: res = (a < b) ? 32'd1 : 32'd0;
          4: res = a ^ b;
          5: if (ins[30]) begin sa = $signed(a) >>> sh; res = sa; end
             else res = a >> sh;
          6: res = a | b;
          default: res = a & b;
        endcase
      end
      LUI:   begin wr = 1; res = iu; end
      AUIPC: begin wr = 1; res = m_pc + iu; end
      BRANCH: begin
        case (f3)
          0: taken = (a == b);
          1: taken = (a != b);
          4: taken = ($signed(a) < $signed(b));
          5: taken = ($signed(a) >= $signed(b));
          6: taken = (a < b);
          7: taken = (a >= b);
          default: taken = 0;
        endcase
        if (taken) npc = m_pc + ib;
      end
      JAL: begin wr = 1; res = m_pc + 4; npc = m_pc + ij; end
      JALR: if (f3 == 0) begin wr = 1; res = m_pc + 4; npc = (a + ii) & ~32'd1; end
      LOAD: if (f3 == 2) begin
        addr = a + ii; wr = 1; res = m_mem[(addr >> 2) % MEM_DEPTH];
      end
      STORE: if (f3 == 2) begin
        addr = a + is_; m_mem[(addr >> 2) % MEM_DEPTH] = b;
      end
      SYSTEM: if (f3 >= 1 && f3 <= 3) begin
        csr_i = int'(ins[31:20]) % CSR_DEPTH;
        old = m_csr[csr_i];
        wr = 1; res = old;
        if (f3 == 1) m_csr[csr_i] = a;
        else if (rs1 != 0) m_csr[csr_i] = (f3 == 2) ? (old | a) : (old & ~a);
      end
      default: ;
    endcase
    if (wr && rd != 0) m_reg[rd] = res;
    m_pc = npc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int ridx [4] = '{1, 4, 5, 3};
    logic [31:0] want [4] = '{32'd73, 32'd7, 32'd80, 32'd66};
    load_start();
    poke_reg(1, 7); poke_reg(2, 7); poke_reg(3, 66); poke_csr(0, 55);
    poke_mem(0, r_type(7'h00, 3, 2, F3_ADD, 1));
    poke_mem(1, r_type(7'h00, 2, 0, F3_ADD, 4));
    poke_mem(2, r_type(7'h00, 2, 1, F3_ADD, 5));
    load_end();
    checks++;
    if (dut.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", dut.pc, 32'h0); end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.reg_bank[ridx[i]] !== want[i]) begin
        errors++; $display("FAIL add_x%0d got %h want %h", ridx[i], dut.reg_bank[ridx[i]], want[i]);
      end
    end
    checks++;
    if (dut.pc !== 32'd12) begin errors++; $display("FAIL add_pc got %h want %h", dut.pc, 32'd12); end
    checks++;
    if (dut.csr_bank[0] !== 32'd55) begin errors++; $display("FAIL reset_csr0 got %h want %h", dut.csr_bank[0], 32'd55); end
  endtask

  task automatic test_op_imm();
    int ridx [8] = '{6, 7, 8, 9, 10, 14, 15, 16};
    logic [31:0] want [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5000, 32'h0000_100C,
                              32'h0, 32'h1, 32'hF, 32'hFFFF_FF0F};
    load_start();
    poke_mem(0, i_type(32'hFFF, 0, F3_ADD, 6, OP_IMM));
    poke_mem(1, i_type(32'h404, 6, F3_SR, 7, OP_IMM));
    poke_mem(2, u_type(32'h12345, 8, LUI));
    poke_mem(3, u_type(32'h1, 9, AUIPC));
    poke_mem(4, i_type(32'h1, 6, F3_SLTU, 10, OP_IMM));
    poke_mem(5, i_type(32'h1, 6, F3_SLT, 14, OP_IMM));
    poke_mem(6, i_type(32'd28, 6, F3_SR, 15, OP_IMM));
    poke_mem(7, i_type(32'h0F0, 6, F3_XOR, 16, OP_IMM));
    load_end();
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut.reg_bank[ridx[i]] !== want[i]) begin
        errors++; $display("FAIL opimm_x%0d got %h want %h", ridx[i], dut.reg_bank[ridx[i]], want[i]);
      end
    end
    checks++;
    if (dut.pc !== 32'd32) begin errors++; $display("FAIL opimm_pc got %h want %h", dut.pc, 32'd32); end
  endtask

  task automatic test_branch_jump();
    logic [31:0] want_pc [6] = '{32'd8, 32'd16, 32'd20, 32'd36, 32'd24, 32'd28};
    load_start();
    poke_reg(1, 7); poke_reg(2, 7); poke_reg(6, 32'hFFFF_FFFF); poke_reg(17, 1);
    poke_mem(0, b_type(32'd8, 1, 2, F3_BEQ));
    poke_mem(1, i_type(32'd1, 0, F3_ADD, 20, OP_IMM));
    poke_mem(2, b_type(32'd8, 17, 6, F3_BLT));
    poke_mem(3, i_type(32'd2, 0, F3_ADD, 20, OP_IMM));
    poke_mem(4, b_type(32'd8, 17, 6, F3_BLTU));
    poke_mem(5, j_type(32'd16, 1));
    poke_mem(6, i_type(32'd5, 0, F3_ADD, 21, OP_IMM));
    poke_mem(9, i_type(32'd1, 1, F3_JALR, 0, JALR));
    load_end();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (dut.pc !== want_pc[i]) begin
        errors++; $display("FAIL branch_pc step%0d got %h want %h", i, dut.pc, want_pc[i]);
      end
      if (i == 3) begin
        checks++;
        if (dut.reg_bank[1] !== 32'd24) begin errors++; $display("FAIL jal_link got %h want %h", dut.reg_bank[1], 32'd24); end
      end
    end
    checks++;
    if (dut.reg_bank[20] !== 32'd0) begin errors++; $display("FAIL skipped_x20 got %h want %h", dut.reg_bank[20], 32'd0); end
    checks++;
    if (dut.reg_bank[21] !== 32'd5) begin errors++; $display("FAIL landing_x21 got %h want %h", dut.reg_bank[21], 32'd5); end
  endtask

  task automatic test_memory();
    logic [31:0] patch;
    patch = i_type(32'd9, 0, F3_ADD, 23, OP_IMM);
    load_start();
    poke_reg(3, 66); poke_reg(22, patch); poke_reg(25, 32'h1000);
    poke_mem(0, s_type(32'd400, 3, 0));
    poke_mem(1, i_type(32'd400, 0, F3_WORD, 11, LOAD));
    poke_mem(2, s_type(32'd12, 22, 0));
    poke_mem(4, i_type(32'd400, 25, F3_WORD, 24, LOAD));
    load_end();
    tick();
    checks++;
    if (dut.mem_bank[100] !== 32'd66) begin errors++; $display("FAIL sw_mem100 got %h want %h", dut.mem_bank[100], 32'd66); end
    repeat (4) tick();
    checks++;
    if (dut.reg_bank[11] !== 32'd66) begin errors++; $display("FAIL lw_x11 got %h want %h", dut.reg_bank[11], 32'd66); end
    checks++;
    if (dut.mem_bank[3] !== patch) begin errors++; $display("FAIL sw_patch got %h want %h", dut.mem_bank[3], patch); end
    checks++;
    if (dut.reg_bank[23] !== 32'd9) begin errors++; $display("FAIL patched_fetch got %h want %h", dut.reg_bank[23], 32'd9); end
    checks++;
    if (dut.reg_bank[24] !== 32'd66) begin errors++; $display("FAIL lw_wrap got %h want %h", dut.reg_bank[24], 32'd66); end
    checks++;
    if (dut.pc !== 32'd20) begin errors++; $display("FAIL mem_pc got %h want %h", dut.pc, 32'd20); end
  endtask

  task automatic test_csr();
    int ridx [4] = '{12, 13, 14, 15};
    logic [31:0] want_rd  [4] = '{32'd55, 32'd7, 32'd7, 32'd3};
    logic [31:0] want_csr [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    load_start();
    poke_reg(2, 7); poke_csr(0, 55); poke_csr(4095, 3);
    poke_mem(0, i_type(32'h000, 2, F3_CSRRW, 12, SYSTEM));
    poke_mem(1, i_type(32'h000, 0, F3_CSRRS, 13, SYSTEM));
    poke_mem(2, i_type(32'h000, 2, F3_CSRRC, 14, SYSTEM));
    poke_mem(3, i_type(32'hFFF, 2, F3_CSRRS, 15, SYSTEM));
    load_end();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut.reg_bank[ridx[i]] !== want_rd[i]) begin
        errors++; $display("FAIL csr_rd_x%0d got %h want %h", ridx[i], dut.reg_bank[ridx[i]], want_rd[i]);
      end
      checks++;
      if (dut.csr_bank[0] !== want_csr[i]) begin
        errors++; $display("FAIL csr0 step%0d got %h want %h", i, dut.csr_bank[0], want_csr[i]);
      end
    end
    checks++;
    if (dut.csr_bank[4095] !== 32'd7) begin errors++; $display("FAIL csr_fff got %h want %h", dut.csr_bank[4095], 32'd7); end
  endtask

  task automatic test_x0_mid_reset();
    load_start();
    poke_reg(2, 7); poke_reg(3, 66);
    poke_mem(0, r_type(7'h00, 3, 2, F3_ADD, 0));
    poke_mem(1, i_type(32'd11, 0, F3_ADD, 18, OP_IMM));
    poke_mem(2, i_type(32'd12, 0, F3_ADD, 19, OP_IMM));
    poke_mem(3, i_type(32'd99, 0, F3_ADD, 18, OP_IMM));
    load_end();
    tick();
    checks++;
    if (dut.reg_bank[0] !== 32'd0) begin errors++; $display("FAIL x0_write got %h want %h", dut.reg_bank[0], 32'd0); end
    repeat (2) tick();
    checks++;
    if (dut.pc !== 32'd12) begin errors++; $display("FAIL pre_reset_pc got %h want %h", dut.pc, 32'd12); end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checks++;
    if (dut.pc !== 32'd0) begin errors++; $display("FAIL mid_reset_pc got %h want %h", dut.pc, 32'd0); end
    checks++;
    if (dut.reg_bank[18] !== 32'd11) begin errors++; $display("FAIL reset_no_write got %h want %h", dut.reg_bank[18], 32'd11); end
    checks++;
    if (dut.reg_bank[19] !== 32'd12) begin errors++; $display("FAIL reset_retain got %h want %h", dut.reg_bank[19], 32'd12); end
    tick();
    checks++;
    if (dut.pc !== 32'd4) begin errors++; $display("FAIL post_reset_pc got %h want %h", dut.pc, 32'd4); end
  endtask

  // Random instruction drawn from a mix that keeps stores in a dedicated data window.
  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [31:0] imm;
    int kind;
    logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    kind = $urandom_range(0, 10);
    case (kind)
      0, 1, 2: return r_type(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                             rs2, rs1, f3, rd);
      3, 4: begin
        imm = 32'($urandom_range(0, 4095));
        if (f3 == 1) imm = 32'(rs2);
        if (f3 == 5) imm = ($urandom_range(0, 1) == 1) ? (32'h400 | 32'(rs2)) : 32'(rs2);
        return i_type(imm, rs1, f3, rd, OP_IMM);
      end
      5: return u_type(32'($urandom), rd, ($urandom_range(0, 1) == 1) ? LUI : AUIPC);
      6: return s_type(32'd1024 + 32'd4 * 32'($urandom_range(0, 255)), rs2, 0);
      7: return i_type(32'd1024 + 32'd4 * 32'($urandom_range(0, 255)), 0, F3_WORD, rd, LOAD);
      8: return b_type(32'd4 * 32'($urandom_range(1, 8)), rs2, rs1, br_f3[$urandom_range(0, 5)]);
      9: return j_type(32'd4 * 32'($urandom_range(1, 16)), rd);
      default: return i_type(32'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 5'd0 : rs1,
                             3'($urandom_range(1, 3)), rd, SYSTEM);
    endcase
  endfunction

  task automatic test_random_program();
    int bad_reg;
    load_start();
    for (int i = 1; i < 32; i++)
      poke_reg(i, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : 32'($urandom));
    for (int i = 0; i < 8; i++)     poke_csr(i, 32'($urandom));
    for (int i = 0; i < 256; i++)   poke_mem(i, rand_instr());
    for (int i = 256; i < 512; i++) poke_mem(i, 32'($urandom));
    load_end();
    for (int s = 0; s < RAND_STEPS; s++) begin
      model_step();
      tick();
      checks++;
      if (dut.pc !== m_pc) begin errors++; $display("FAIL rand_pc step%0d got %h want %h", s, dut.pc, m_pc); end
      bad_reg = -1;
      for (int r = 0; r < 32; r++)
        if (bad_reg < 0 && dut.reg_bank[r] !== m_reg[r]) bad_reg = r;
      checks++;
      if (bad_reg >= 0) begin
        errors++;
        $display("FAIL rand_reg step%0d x%0d got %h want %h", s, bad_reg, dut.reg_bank[bad_reg], m_reg[bad_reg]);
      end
    end
    for (int i = 0; i < 512; i++) begin
      checks++;
      if (dut.mem_bank[i] !== m_mem[i]) begin
        errors++; $display("FAIL rand_mem[%0d] got %h want %h", i, dut.mem_bank[i], m_mem[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut.csr_bank[i] !== m_csr[i]) begin
        errors++; $display("FAIL rand_csr[%0d] got %h want %h", i, dut.csr_bank[i], m_csr[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_op_imm();
    test_branch_jump();
    test_memory();
    test_csr();
    test_x0_mid_reset();
    test_random_program();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
